// File: rtl/spram_pwr_arbiter.sv
// Two-master round-robin arbiter in front of the SPRAM wrapper, with idle/WFI
// driven stand-by and automatic wake-up on demand.
module spram_pwr_arbiter #(
   parameter int ADDR_W      = 16,
   parameter int IDLE_CYCLES = 16,
   parameter int WAKE_CYCLES = 1,
   parameter int CNT_W       = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wfi,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [3:0]        m0_be,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [31:0]       m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [31:0]       m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [3:0]        m1_be,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [31:0]       m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [31:0]       m1_rdata,
   output logic              mem_sel,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_din,
   input  logic [31:0]       mem_dout,
   output logic              mem_ls_req,
   output logic              mem_ds_req,
   output logic              standby
);

   typedef enum logic [1:0] {
      ST_ACTIVE  = 2'd0,
      ST_STANDBY = 2'd1,
      ST_WAKE    = 2'd2
   } state_t;

   localparam logic             IDLE_EN   = (IDLE_CYCLES != 0);
   localparam logic [CNT_W-1:0] IDLE_LAST = (IDLE_CYCLES == 0) ? {CNT_W{1'b0}} : CNT_W'(IDLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAKE_LAST = (WAKE_CYCLES <= 1) ? {CNT_W{1'b0}} : CNT_W'(WAKE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   state_t           state_r, state_nxt_s;
   logic             rr_r, rr_nxt_s;          // 0: m0 has priority on contention
   logic [CNT_W-1:0] idle_cnt_r, idle_nxt_s;
   logic [CNT_W-1:0] wake_cnt_r, wake_nxt_s;
   logic             gnt0_s, gnt1_s, any_req_s;
   logic             rv0_r, rv1_r;
   logic [31:0]      rdata0_r, rdata1_r;

   assign any_req_s = m0_req | m1_req;

   // Next-state, arbitration and counter update.
   always_comb begin
      state_nxt_s = state_r;
      rr_nxt_s    = rr_r;
      idle_nxt_s  = idle_cnt_r;
      wake_nxt_s  = wake_cnt_r;
      gnt0_s      = 1'b0;
      gnt1_s      = 1'b0;
      case (state_r)
         ST_ACTIVE: begin
            // Grants are suppressed while reset is asserted so outputs drop at once.
            if (rst_n) begin
               if (m0_req && m1_req) begin
                  gnt0_s   = ~rr_r;
                  gnt1_s   = rr_r;
                  rr_nxt_s = ~rr_r;
               end else begin
                  gnt0_s = m0_req;
                  gnt1_s = m1_req;
               end
            end else begin
               gnt0_s = 1'b0;
               gnt1_s = 1'b0;
            end
            if (any_req_s) begin
               idle_nxt_s = {CNT_W{1'b0}};
            end else if (idle_cnt_r != CNT_MAX) begin
               idle_nxt_s = idle_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
               idle_nxt_s = idle_cnt_r;
            end
            if (!any_req_s && (wfi || (IDLE_EN && idle_cnt_r >= IDLE_LAST))) begin
               state_nxt_s = ST_STANDBY;
               idle_nxt_s  = {CNT_W{1'b0}};
            end else begin
               state_nxt_s = ST_ACTIVE;
            end
         end
         ST_STANDBY: begin
            idle_nxt_s = {CNT_W{1'b0}};
            if (any_req_s) begin
               state_nxt_s = ST_WAKE;
               wake_nxt_s  = {CNT_W{1'b0}};
            end else begin
               state_nxt_s = ST_STANDBY;
            end
         end
         ST_WAKE: begin
            idle_nxt_s = {CNT_W{1'b0}};
            if (wake_cnt_r >= WAKE_LAST) begin
               state_nxt_s = ST_ACTIVE;
               wake_nxt_s  = {CNT_W{1'b0}};
            end else begin
               wake_nxt_s = wake_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_nxt_s = ST_ACTIVE;
         end
      endcase
   end

   // SPRAM port mux from the granted master; reads never carry byte enables.
   always_comb begin
      mem_we   = 1'b0;
      mem_be   = 4'h0;
      mem_addr = {ADDR_W{1'b0}};
      mem_din  = 32'h0;
      if (gnt1_s) begin
         mem_we   = m1_we;
         mem_be   = m1_we ? m1_be : 4'h0;
         mem_addr = m1_addr;
         mem_din  = m1_wdata;
      end else if (gnt0_s) begin
         mem_we   = m0_we;
         mem_be   = m0_we ? m0_be : 4'h0;
         mem_addr = m0_addr;
         mem_din  = m0_wdata;
      end else begin
         mem_we = 1'b0;
      end
   end

   // State, pointer, counters and read-return tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_ACTIVE;
         rr_r       <= 1'b0;
         idle_cnt_r <= {CNT_W{1'b0}};
         wake_cnt_r <= {CNT_W{1'b0}};
         rv0_r      <= 1'b0;
         rv1_r      <= 1'b0;
         rdata0_r   <= 32'h0;
         rdata1_r   <= 32'h0;
      end else begin
         state_r    <= state_nxt_s;
         rr_r       <= rr_nxt_s;
         idle_cnt_r <= idle_nxt_s;
         wake_cnt_r <= wake_nxt_s;
         rv0_r      <= gnt0_s & ~m0_we;
         rv1_r      <= gnt1_s & ~m1_we;
         if (rv0_r) rdata0_r <= mem_dout;
         if (rv1_r) rdata1_r <= mem_dout;
      end
   end

   assign m0_gnt     = gnt0_s;
   assign m1_gnt     = gnt1_s;
   assign mem_sel    = gnt0_s | gnt1_s;
   assign m0_rvalid  = rv0_r;
   assign m1_rvalid  = rv1_r;
   // Read data is live in the return cycle, then held from the capture register.
   assign m0_rdata   = rv0_r ? mem_dout : rdata0_r;
   assign m1_rdata   = rv1_r ? mem_dout : rdata1_r;
   assign standby    = (state_r == ST_STANDBY);
   assign mem_ls_req = (state_r == ST_STANDBY);
   assign mem_ds_req = 1'b0;

endmodule

// File: tb/tb_spram_pwr_arbiter.sv
// Directed bench for spram_pwr_arbiter: arbitration, read return, power states, reset.
module tb_spram_pwr_arbiter;
   logic        clk = 1'b0;
   logic        rst_n, wfi;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [3:0]  m0_be, m1_be;
   logic [15:0] m0_addr, m1_addr;
   logic [31:0] m0_wdata, m1_wdata;
   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mem_sel, mem_we, mem_ls_req, mem_ds_req, standby;
   logic [3:0]  mem_be;
   logic [15:0] mem_addr;
   logic [31:0] mem_din, mem_dout;
   int          checks = 0;
   int          errors = 0;

   spram_pwr_arbiter #(.ADDR_W(16), .IDLE_CYCLES(16), .WAKE_CYCLES(1), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .wfi(wfi),
      .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .mem_sel(mem_sel), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_ls_req(mem_ls_req),
      .mem_ds_req(mem_ds_req), .standby(standby)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks follow 2 units later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic e0, e1, p0;
      rst_n = 1'b0; wfi = 1'b0;
      m0_req = 1'b0; m0_we = 1'b0; m0_be = 4'h0; m0_addr = 16'h0; m0_wdata = 32'h0;
      m1_req = 1'b0; m1_we = 1'b0; m1_be = 4'h0; m1_addr = 16'h0; m1_wdata = 32'h0;
      mem_dout = 32'h0;
      #3;
      check("rst_gnt", {31'h0, m0_gnt | m1_gnt}, 32'h0);
      check("rst_sel", {31'h0, mem_sel}, 32'h0);
      check("rst_rvalid", {30'h0, m0_rvalid, m1_rvalid}, 32'h0);
      check("rst_ls", {31'h0, mem_ls_req}, 32'h0);
      check("rst_standby", {31'h0, standby}, 32'h0);
      check("ds_req", {31'h0, mem_ds_req}, 32'h0);
      #9 rst_n = 1'b1;

      // Single read from m0
      tick();
      m0_req = 1'b1; m0_we = 1'b0; m0_be = 4'hF; m0_addr = 16'h0010;
      #2;
      check("rd_gnt", {31'h0, m0_gnt}, 32'h1);
      check("rd_sel", {31'h0, mem_sel}, 32'h1);
      check("rd_addr", {16'h0, mem_addr}, 32'h0010);
      check("rd_be0", {28'h0, mem_be}, 32'h0);
      check("rd_we", {31'h0, mem_we}, 32'h0);
      tick();
      m0_req = 1'b0; mem_dout = 32'hDEADBEEF;
      #2;
      check("rd_rvalid", {31'h0, m0_rvalid}, 32'h1);
      check("rd_rdata", m0_rdata, 32'hDEADBEEF);
      check("rd_idle_sel", {31'h0, mem_sel}, 32'h0);
      tick();
      mem_dout = 32'h11111111;
      #2;
      check("rd_rvalid_off", {31'h0, m0_rvalid}, 32'h0);
      check("rd_hold", m0_rdata, 32'hDEADBEEF);

      // Contention: expect m0, m1, m0, m1
      p0 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         m0_req = 1'b1; m0_addr = 16'h0100; m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0200;
         #2;
         e0 = (i % 2 == 0);
         e1 = ~e0;
         check("cont_gnt0", {31'h0, m0_gnt}, {31'h0, e0});
         check("cont_gnt1", {31'h0, m1_gnt}, {31'h0, e1});
         check("cont_addr", {16'h0, mem_addr}, e0 ? 32'h0100 : 32'h0200);
         check("cont_rv0", {31'h0, m0_rvalid}, {31'h0, p0});
         p0 = e0;
      end

      // m1 partial write
      tick();
      m0_req = 1'b0; m1_req = 1'b1; m1_we = 1'b1; m1_be = 4'h3; m1_addr = 16'h0055;
      m1_wdata = 32'h12345678;
      #2;
      check("wr_gnt", {31'h0, m1_gnt}, 32'h1);
      check("wr_we", {31'h0, mem_we}, 32'h1);
      check("wr_be", {28'h0, mem_be}, 32'h3);
      check("wr_din", mem_din, 32'h12345678);
      check("wr_addr", {16'h0, mem_addr}, 32'h0055);

      // Idle timeout: standby appears on the 17th idle cycle (index 16)
      for (int i = 0; i <= 16; i++) begin
         tick();
         m1_req = 1'b0; m1_we = 1'b0;
         #2;
         if (i == 0) check("wr_no_rvalid", {31'h0, m1_rvalid}, 32'h0);
         check("idle_standby", {31'h0, standby}, {31'h0, (i == 16)});
         check("idle_ls", {31'h0, mem_ls_req}, {31'h0, (i == 16)});
      end

      // Wake on m0 demand
      tick();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0020;
      #2;
      check("wk0_gnt", {31'h0, m0_gnt}, 32'h0);
      check("wk0_ls", {31'h0, mem_ls_req}, 32'h1);
      tick();
      #2;
      check("wk1_ls", {31'h0, mem_ls_req}, 32'h0);
      check("wk1_standby", {31'h0, standby}, 32'h0);
      check("wk1_gnt", {31'h0, m0_gnt}, 32'h0);
      check("wk1_sel", {31'h0, mem_sel}, 32'h0);
      tick();
      #2;
      check("wk2_gnt", {31'h0, m0_gnt}, 32'h1);
      check("wk2_addr", {16'h0, mem_addr}, 32'h0020);
      tick();
      m0_req = 1'b0; mem_dout = 32'hCAFEF00D;
      #2;
      check("wk_rdata", m0_rdata, 32'hCAFEF00D);
      check("wk_rvalid", {31'h0, m0_rvalid}, 32'h1);

      // WFI with no request
      tick();
      wfi = 1'b1;
      #2;
      check("wfi0_standby", {31'h0, standby}, 32'h0);
      tick();
      #2;
      check("wfi1_standby", {31'h0, standby}, 32'h1);
      // Wake with wfi held; the request is served and state stays ACTIVE
      tick();
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0030;
      #2;
      check("wfi_sb_hold", {31'h0, standby}, 32'h1);
      tick();
      tick();
      #2;
      check("wfi_m1_gnt", {31'h0, m1_gnt}, 32'h1);
      check("wfi_active", {31'h0, standby}, 32'h0);
      tick();
      m1_req = 1'b0;
      #2;
      check("wfi_m1_rvalid", {31'h0, m1_rvalid}, 32'h1);
      check("wfi_post_active", {31'h0, standby}, 32'h0);
      tick();
      wfi = 1'b0;
      #2;
      check("wfi_reenter", {31'h0, standby}, 32'h1);

      // Async reset between grant and rvalid
      tick();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0040;
      tick();
      tick();
      #2;
      check("ar_gnt", {31'h0, m0_gnt}, 32'h1);
      #1 rst_n = 1'b0;
      #1;
      check("ar_gnt_off", {31'h0, m0_gnt}, 32'h0);
      check("ar_sel_off", {31'h0, mem_sel}, 32'h0);
      check("ar_ls_off", {31'h0, mem_ls_req | standby}, 32'h0);
      for (int i = 0; i < 2; i++) begin
         tick();
         #2;
         check("ar_rvalid", {31'h0, m0_rvalid}, 32'h0);
      end
      m0_req = 1'b0;
      #1 rst_n = 1'b1;
      tick();
      #2;
      check("ar_post_rvalid", {31'h0, m0_rvalid}, 32'h0);
      check("ar_post_rdata", m0_rdata, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout got running exp finished");
      $fatal(1);
   end
endmodule
